// File: rtl/pid_profile_pkg.sv
// Shared types and constants for the PID profile loader (PID_PROFILE_READBACK_EN adds readback).
// Pure definitions: no latency, no flow control.
package pid_profile_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      REPORT  = 3'd5
   } state_t;

   localparam int PID_N_REGS = 9;

   // Byte offsets of the nine PID registers, index 8 being the control register.
   localparam logic [PID_N_REGS-1:0][31:0] PID_REG_OFFSET = {
      32'h20, 32'h1C, 32'h18, 32'h14, 32'h10, 32'h0C, 32'h08, 32'h04, 32'h00
   };

   localparam int STATUS_IDX_LSB      = 0;
   localparam int STATUS_WR_ERR_LSB   = 8;
   localparam int STATUS_MISMATCH_LSB = 16;
   localparam int STATUS_REJECT_BIT   = 31;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [31:0] pack_status(input logic reject, input logic [7:0] mismatch,
                                               input logic [7:0] wr_err, input logic [7:0] idx);
      logic [31:0] s;
      s = '0;
      s[STATUS_REJECT_BIT]                            = reject;
      s[STATUS_MISMATCH_LSB +: 8]                     = mismatch;
      s[STATUS_WR_ERR_LSB +: 8]                       = wr_err;
      s[STATUS_IDX_LSB +: 8]                          = idx;
      return s;
   endfunction

endpackage

// File: rtl/pid_profile_loader_axil_single_transfer.sv
// One AXI-lite write (independent AW/W completion, then B) or read (AR, then R); the caller's FSM
// sequences phases. Combinational handshakes, waits indefinitely on the slave. PID_PROFILE_READBACK_EN enables AR/R.
module axil_single_transfer (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_req,
   input  logic        wr_resp,
   input  logic        rd_req,
   input  logic        rd_resp,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        req_done,
   output logic        resp_done,
   output logic [1:0]  resp,
   output logic [31:0] rdata,
   output logic [31:0] axil_awaddr,
   output logic        axil_awvalid,
   input  logic        axil_awready,
   output logic [31:0] axil_wdata,
   output logic [3:0]  axil_wstrb,
   output logic        axil_wvalid,
   input  logic        axil_wready,
   input  logic [1:0]  axil_bresp,
   input  logic        axil_bvalid,
   output logic        axil_bready,
   output logic [31:0] axil_araddr,
   output logic        axil_arvalid,
   input  logic        axil_arready,
   input  logic [31:0] axil_rdata,
   input  logic [1:0]  axil_rresp,
   input  logic        axil_rvalid,
   output logic        axil_rready
);

   logic aw_done, w_done;
   logic aw_ok, w_ok, wr_done;

   assign axil_awaddr  = addr;
   assign axil_wdata   = wdata;
   assign axil_wstrb   = 4'hF;
   assign axil_awvalid = wr_req & ~aw_done;
   assign axil_wvalid  = wr_req & ~w_done;
   assign axil_bready  = wr_resp;

   // AW and W may complete in either order or together; remember whichever finished first.
   assign aw_ok   = aw_done | (axil_awvalid & axil_awready);
   assign w_ok    = w_done  | (axil_wvalid  & axil_wready);
   assign wr_done = wr_req & aw_ok & w_ok;

   always_ff @(posedge clock) begin
      if (!reset) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (wr_done) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (wr_req) begin
         aw_done <= aw_ok;
         w_done  <= w_ok;
      end
   end

`ifdef PID_PROFILE_READBACK_EN
   assign axil_araddr  = addr;
   assign axil_arvalid = rd_req;
   assign axil_rready  = rd_resp;
   assign req_done     = wr_done | (rd_req & axil_arready);
   assign resp_done    = (wr_resp & axil_bvalid) | (rd_resp & axil_rvalid);
   assign resp         = rd_resp ? axil_rresp : axil_bresp;
   assign rdata        = axil_rdata;
`else
   logic unused_rd;
   assign unused_rd    = ^{rd_req, rd_resp, axil_arready, axil_rdata, axil_rresp, axil_rvalid};
   assign axil_araddr  = 32'h0;
   assign axil_arvalid = 1'b0;
   assign axil_rready  = 1'b0;
   assign req_done     = wr_done;
   assign resp_done    = wr_resp & axil_bvalid;
   assign resp         = axil_bresp;
   assign rdata        = 32'h0;
`endif

endmodule

// File: rtl/pid_profile_loader.sv
// Loads one of N_PROFILES nine-word gain sets into a PID over AXI-lite, reports on a status stream.
// Best case 18 cycles per load (36 with PID_PROFILE_READBACK_EN); index accepted only when idle.
module pid_profile_loader
   import pid_profile_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   parameter int          N_PROFILES   = 4,
   parameter logic [N_PROFILES-1:0][PID_N_REGS-1:0][31:0] PROFILES = '0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        profile_select_valid,
   output logic        profile_select_ready,
   input  logic [31:0] profile_select_data,
   output logic        status_valid,
   input  logic        status_ready,
   output logic [31:0] status_data,
   output logic [31:0] axil_awaddr,
   output logic        axil_awvalid,
   input  logic        axil_awready,
   output logic [31:0] axil_wdata,
   output logic [3:0]  axil_wstrb,
   output logic        axil_wvalid,
   input  logic        axil_wready,
   input  logic [1:0]  axil_bresp,
   input  logic        axil_bvalid,
   output logic        axil_bready,
   output logic [31:0] axil_araddr,
   output logic        axil_arvalid,
   input  logic        axil_arready,
   input  logic [31:0] axil_rdata,
   input  logic [1:0]  axil_rresp,
   input  logic        axil_rvalid,
   output logic        axil_rready,
   output logic        busy
);

   localparam int         IDX_W     = (N_PROFILES > 1) ? $clog2(N_PROFILES) : 1;
   localparam logic [8:0] N_PROF_U  = 9'(N_PROFILES);

   state_t      state, next_state;
   logic [7:0]  idx;
   logic [3:0]  cnt;
   logic        reject;
   logic [7:0]  wr_err;
   logic [7:0]  mismatch;

   logic        accept, in_range;
   logic        wr_req, wr_resp, rd_req, rd_resp;
   logic        req_done, resp_done;
   logic [1:0]  resp;
   logic [31:0] rdata;
   logic [31:0] addr, table_word;
   logic [IDX_W-1:0] idx_sel;

   assign accept     = profile_select_valid & profile_select_ready;
   assign in_range   = {1'b0, profile_select_data[7:0]} < N_PROF_U;
   assign idx_sel    = idx[IDX_W-1:0];
   assign table_word = PROFILES[idx_sel][cnt];
   assign addr       = BASE_ADDRESS + PID_REG_OFFSET[cnt];

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (profile_select_valid) next_state = in_range ? WR_REQ : REPORT;
         WR_REQ:  if (req_done) next_state = WR_RESP;
         WR_RESP: if (resp_done) begin
`ifdef PID_PROFILE_READBACK_EN
            next_state = (cnt == 4'd0) ? RD_REQ : WR_REQ;
`else
            next_state = (cnt == 4'd0) ? REPORT : WR_REQ;
`endif
         end
`ifdef PID_PROFILE_READBACK_EN
         RD_REQ:  if (req_done) next_state = RD_RESP;
         RD_RESP: if (resp_done) next_state = (cnt == 4'd0) ? REPORT : RD_REQ;
`endif
         REPORT:  if (status_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      profile_select_ready = (state == IDLE);
      busy                 = (state != IDLE);
      status_valid         = (state == REPORT);
      status_data          = 32'h0;
      if (state == REPORT) status_data = pack_status(reject, mismatch, wr_err, idx);
      wr_req  = (state == WR_REQ);
      wr_resp = (state == WR_RESP);
      rd_req  = (state == RD_REQ);
      rd_resp = (state == RD_RESP);
   end

   // Counter walks 8 down to 0 so the control register lands last; it reloads for the read pass.
   always_ff @(posedge clock) begin
      if (!reset) begin
         idx      <= 8'h0;
         cnt      <= 4'h0;
         reject   <= 1'b0;
         wr_err   <= 8'h0;
         mismatch <= 8'h0;
      end else begin
         if (state == IDLE && accept) begin
            idx      <= profile_select_data[7:0];
            cnt      <= 4'd8;
            reject   <= ~in_range;
            wr_err   <= 8'h0;
            mismatch <= 8'h0;
         end
         if (wr_resp && resp_done) begin
            if (resp != 2'b00) wr_err <= sat_inc(wr_err);
            cnt <= (cnt == 4'd0) ? 4'd8 : cnt - 4'd1;
         end
`ifdef PID_PROFILE_READBACK_EN
         if (rd_resp && resp_done) begin
            if (rdata != table_word || resp != 2'b00) mismatch <= sat_inc(mismatch);
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
         end
`endif
      end
   end

`ifndef PID_PROFILE_READBACK_EN
   logic unused_rdata;
   assign unused_rdata = ^rdata;
`endif
   logic unused_sel;
   assign unused_sel = ^profile_select_data[31:8];

   axil_single_transfer u_xfer (
      .clock        (clock),
      .reset        (reset),
      .wr_req       (wr_req),
      .wr_resp      (wr_resp),
      .rd_req       (rd_req),
      .rd_resp      (rd_resp),
      .addr         (addr),
      .wdata        (table_word),
      .req_done     (req_done),
      .resp_done    (resp_done),
      .resp         (resp),
      .rdata        (rdata),
      .axil_awaddr  (axil_awaddr),
      .axil_awvalid (axil_awvalid),
      .axil_awready (axil_awready),
      .axil_wdata   (axil_wdata),
      .axil_wstrb   (axil_wstrb),
      .axil_wvalid  (axil_wvalid),
      .axil_wready  (axil_wready),
      .axil_bresp   (axil_bresp),
      .axil_bvalid  (axil_bvalid),
      .axil_bready  (axil_bready),
      .axil_araddr  (axil_araddr),
      .axil_arvalid (axil_arvalid),
      .axil_arready (axil_arready),
      .axil_rdata   (axil_rdata),
      .axil_rresp   (axil_rresp),
      .axil_rvalid  (axil_rvalid),
      .axil_rready  (axil_rready)
   );

endmodule

// File: doc/pid_profile_loader.md
# pid_profile_loader

Sequencer that programs a PID controller's nine-word register file over AXI-lite, acting as the initiator against the controller's `axil` slave port. A profile index arrives on an AXI-stream. The block writes the selected gain/limit set from a parameter table, optionally reads it back, then reports completion on a status stream. It sits between a supervisory controller (gain scheduling, start-up) and one PID instance.

## Interface
- `BASE_ADDRESS`, default 0: byte address of the target PID register 0.
- `N_PROFILES`, default 4: number of stored profiles; valid range 1..256.
- `PROFILES`, default all-zero: `[N_PROFILES-1:0][8:0]` table of 32-bit words; word i targets register i.
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-low.
- `profile_select`  axi_stream.slave  32: data[7:0] is the profile index; upper bits are ignored.
- `status`  axi_stream.master  32: completion report.
- `axil`  axi_lite.master  32 addr / 32 data: link to the PID register file.
- `busy`  out  1: high from index acceptance until the status handshake.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, REPORT.
- IDLE
  - `profile_select.ready`=1 only in this state.
  - On handshake, latch the index and set the register counter to 8.
  - If index >= N_PROFILES, go straight to REPORT with the reject bit set. No AXI traffic occurs.
- WR_REQ
  - Drive awaddr = BASE_ADDRESS + 4*counter, wdata = PROFILES[idx][counter], wstrb = 4'hF.
  - Assert awvalid and wvalid. Each drops independently on its own handshake.
  - Enter WR_RESP once both have handshaken; same-cycle handshakes are allowed.
- WR_RESP
  - bready=1. On bvalid, if bresp != 0, increment the write-error count (saturating at 255).
  - Then go to REPORT if counter=0, otherwise decrement the counter and return to WR_REQ.
  - Write order is 8 down to 0, so the control register is written last.
- RD_REQ / RD_RESP: present only with readback (see Configuration).
- REPORT
  - status.valid=1 with data = {reject[31], 7'b0, mismatch[23:16], wr_err[15:8], index[7:0]}.
  - Held stable until status.ready; then return to IDLE.
- Counts are cleared on each new index acceptance.
- There is no transaction timeout. A hung slave holds the FSM indefinitely, by design.
- A new profile_select arriving while busy is not accepted. Upstream holds it, per AXI-stream.

## Timing
- Reset values of all outputs are 0: awvalid, wvalid, arvalid, bready, rready, status.valid, status.data, busy. `profile_select.ready`=1 (IDLE).
- Index handshake at cycle N → awvalid/wvalid high at N+1, and busy high at N+1.
- Best-case write of one word is 2 cycles: AW/W handshake, then B.
- Best-case full load with readback disabled: 18 cycles from the first awvalid to status.valid.
- A rejected index gives status.valid at N+1.
- bvalid/rvalid are ignored outside their response states.
- Reset asserted mid-sequence:
  - All valids drop on the next edge and the FSM returns to IDLE.
  - The partial register load is not rolled back.
  - The target shares the same reset.

## Configuration
- Macro: `PID_PROFILE_READBACK_EN`.
- Defined:
  - After the write pass, the counter is reloaded to 8.
  - RD_REQ asserts arvalid at the same address pattern until arready.
  - RD_RESP holds rready=1 and, on rvalid, compares rdata with the table word.
  - Each mismatch, or rresp != 0, increments the mismatch count (saturating).
  - After counter 0, go to REPORT. Best case adds 18 cycles.
- Undefined: the RD states and the AR/R logic are absent; arvalid and rready are tied 0; the mismatch field is always 0.

## Structure
- Package `pid_profile_pkg` holds:
  - state enum;
  - `PID_N_REGS`=9;
  - register offset constants (0x0..0x20);
  - status field bit positions;
  - reject bit index.
- Sub-module `axil_single_transfer`:
  - performs one write or one read: independent AW/W completion, B/R capture, response code out;
  - the FSM sequences it.

## Test plan
- **Nominal load:** index 1, always-ready slave, bresp=0.
  - 9 writes to 0x20,0x1C..0x0 with PROFILES[1] data in that order.
  - status=0x00000001 after 18 cycles; busy low after the status handshake.
- **Backpressure:** slave delays awready 3 cycles and wready 1 cycle independently.
  - Each valid holds until its own handshake; no duplicate or dropped writes.
- **Error response:** bresp=2'b10 on registers 5 and 2.
  - status[15:8]=2; all 9 writes still issued.
- **Out-of-range:** index=N_PROFILES with N_PROFILES=4.
  - status=0x80000004 one cycle later; zero AW/W activity.
- **Readback (macro defined):** slave corrupts rdata of register 3.
  - status[23:16]=1; 9 reads follow the 9 writes.
- **Reset mid-load:** reset low during the WR_RESP of register 4.
  - All valids and busy are 0 next cycle; a new index then runs a clean full sequence.
